// File: rtl/pi_1_unshuffle_buffer.sv
// Collects K beats of K CNU messages and presents the rebuilt K*K vector in PE column-major order.
// out_valid follows the last accepted beat by one cycle; either side only stalls, and no data is lost.
module pi_1_unshuffle_buffer #(
  parameter int K          = 6,
  parameter int DATA_WIDTH = 6,
  parameter int BW         = (K > 1) ? $clog2(K) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [K-1:0][DATA_WIDTH-1:0]     in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [K*K-1:0][DATA_WIDTH-1:0]   out_data,
  output logic [BW-1:0]                    beat_idx,
  output logic                             busy
);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;

  logic [0:0]                         state;
  logic [K*K-1:0][DATA_WIDTH-1:0]     frame_buf;

  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == PRESENT);
  assign out_data  = frame_buf;
  assign busy      = (state == PRESENT) || (beat_idx != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      beat_idx  <= '0;
      frame_buf <= '0;
    end else if (flush) begin
      // Abort wins over any same-cycle handshake; buffer contents are kept.
      state    <= COLLECT;
      beat_idx <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_valid) begin
            for (int x = 0; x < K; x++) begin
              if (beat_idx == BW'(x)) begin
                for (int y = 0; y < K; y++) begin
                  frame_buf[y*K + x] <= in_data[y];
                end
              end
            end
            if (beat_idx == BW'(K-1)) begin
              beat_idx <= '0;
              state    <= PRESENT;
            end else begin
              beat_idx <= beat_idx + BW'(1);
            end
          end
        end
        PRESENT: begin
          if (out_ready) begin
            state <= COLLECT;
          end
        end
        default: begin
          state    <= COLLECT;
          beat_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pi_1_unshuffle_buffer.sv
// Randomised and directed bench for pi_1_unshuffle_buffer against a frame-level reference model.
module tb_pi_1_unshuffle_buffer;

  localparam int K  = 6;
  localparam int DW = 6;
  localparam int BW = $clog2(K);

  typedef logic [K-1:0][DW-1:0]   beat_t;
  typedef logic [K*K-1:0][DW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  beat_t         in_data;
  logic          out_valid;
  logic          out_ready;
  vec_t          out_data;
  logic [BW-1:0] beat_idx;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Reference model: the PE grid as a 2-D array, plus frame phase and beat counter.
  logic [DW-1:0] pe_grid [K][K];   // pe_grid[x][y] = message for PE(x,y)
  bit            m_present;
  int            m_beat;

  pi_1_unshuffle_buffer #(.K(K), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .beat_idx(beat_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic vec_t model_vec();
    vec_t v;
    for (int x = 0; x < K; x++)
      for (int y = 0; y < K; y++)
        v[y*K + x] = pe_grid[x][y];
    return v;
  endfunction

  function automatic beat_t ramp_beat(int x);
    beat_t b;
    for (int y = 0; y < K; y++) b[y] = DW'(K*x + y);
    return b;
  endfunction

  function automatic beat_t fill_beat(logic [DW-1:0] v);
    beat_t b;
    for (int y = 0; y < K; y++) b[y] = v;
    return b;
  endfunction

  task automatic model_reset();
    for (int x = 0; x < K; x++)
      for (int y = 0; y < K; y++)
        pe_grid[x][y] = '0;
    m_present = 0;
    m_beat    = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".in_ready"},  256'(in_ready),  256'(!m_present));
    check({tag, ".out_valid"}, 256'(out_valid), 256'(m_present));
    check({tag, ".beat_idx"},  256'(beat_idx),  256'(m_beat));
    check({tag, ".busy"},      256'(busy),      256'(m_present || m_beat != 0));
    check({tag, ".out_data"},  256'(out_data),  256'(model_vec()));
  endtask

  // Apply inputs for one clock, advance the model, then check at the following negedge.
  task automatic cycle(input string tag, input logic iv, input beat_t d,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    if (fl) begin
      m_present = 0;
      m_beat    = 0;
    end else if (!m_present && iv) begin
      for (int y = 0; y < K; y++) pe_grid[m_beat][y] = d[y];
      m_beat = (m_beat + 1) % K;
      if (m_beat == 0) m_present = 1;
    end else if (m_present && ordy) begin
      m_present = 0;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic ramp_frame(input string tag);
    for (int x = 0; x < K; x++) cycle(tag, 1'b1, ramp_beat(x), 1'b0, 1'b0);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, ".out_data"},  256'(out_data),  256'(0));
    check({tag, ".out_valid"}, 256'(out_valid), 256'(0));
    check({tag, ".beat_idx"},  256'(beat_idx),  256'(0));
    check({tag, ".busy"},      256'(busy),      256'(0));
    check({tag, ".in_ready"},  256'(in_ready),  256'(1));
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t v;
    beat_t rb;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;

    // 1: ramp frame; PI_1 of the output restores CNU order
    ramp_frame("t1");
    v = out_data;
    check("t1.valid_c7", 256'(out_valid), 256'(1));
    check("t1.od1",  256'(v[1]),  256'(6));
    check("t1.od6",  256'(v[6]),  256'(1));
    check("t1.od35", 256'(v[35]), 256'(35));
    for (int x = 0; x < K; x++)
      for (int y = 0; y < K; y++)
        check($sformatf("t1.pi1_%0d", x*K + y), 256'(v[y*K + x]), 256'(x*K + y));

    // 2: output back-pressure, in_valid asserted but ignored while presenting
    for (int i = 0; i < 5; i++) cycle("t2.hold", 1'b1, fill_beat(6'h3f), 1'b0, 1'b0);
    cycle("t2.accept", 1'b0, '0, 1'b1, 1'b0);
    check("t2.in_ready_after", 256'(in_ready), 256'(1));

    // 3: gapped input
    for (int x = 0; x < K; x++) begin
      cycle("t3.beat", 1'b1, ramp_beat(x), 1'b0, 1'b0);
      cycle("t3.gap",  1'b0, fill_beat(6'h2a), 1'b0, 1'b0);
    end
    check("t3.same_as_t1", 256'(out_data), 256'(v));
    cycle("t3.accept", 1'b0, '0, 1'b1, 1'b0);

    // 4: flush colliding with a beat, then a fresh frame
    for (int x = 0; x < 3; x++) cycle("t4.pre", 1'b1, fill_beat(6'h11), 1'b0, 1'b0);
    cycle("t4.flush", 1'b1, fill_beat(6'h22), 1'b0, 1'b1);
    check("t4.beat_idx0", 256'(beat_idx), 256'(0));
    check("t4.busy0",     256'(busy),     256'(0));
    ramp_frame("t4.fresh");
    check("t4.vec", 256'(out_data), 256'(v));
    // flush also beats an output handshake
    cycle("t4.flush_out", 1'b0, '0, 1'b1, 1'b1);
    check("t4.flush_drop_valid", 256'(out_valid), 256'(0));

    // 5: async reset mid-frame and while presenting
    for (int x = 0; x < 4; x++) cycle("t5.pre", 1'b1, ramp_beat(x), 1'b0, 1'b0);
    check("t5.beat4", 256'(beat_idx), 256'(4));
    async_reset("t5.mid");
    ramp_frame("t5.frame");
    async_reset("t5.present");

    // 6: two frames, no residue
    for (int x = 0; x < K; x++) cycle("t6.ones", 1'b1, fill_beat(6'h3f), 1'b0, 1'b0);
    cycle("t6.acc1", 1'b0, '0, 1'b1, 1'b0);
    for (int x = 0; x < K; x++)
      cycle("t6.alt", 1'b1, fill_beat((x % 2 == 0) ? 6'h15 : 6'h2a), 1'b0, 1'b0);
    for (int x = 0; x < K; x++)
      for (int y = 0; y < K; y++)
        check("t6.entry", 256'(out_data[y*K + x]), 256'((x % 2 == 0) ? 6'h15 : 6'h2a));
    cycle("t6.acc2", 1'b0, '0, 1'b1, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      for (int y = 0; y < K; y++) rb[y] = DW'($urandom_range(0, 63));
      cycle("rand", 1'($urandom_range(0, 1)), rb, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 19) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
